// File: rtl/spi_sideload_bridge.sv
// SPI mode-0 slave bridging an external host to the core's sideload ports.
// Frames are CMD(8) ADDR(32) followed by write data, or turnaround plus read data.
// SPI pins are oversampled in the clk domain; sclk must be at most clk/8.
module spi_sideload_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned BOOT_RUN    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_imem_we,
    output logic [31:0] spi_imem_addr,
    output logic [31:0] spi_imem_data,
    output logic [31:0] spi_dmem_addr,
    input  logic [31:0] spi_dmem_data,
    input  logic [31:0] debug_pc,
    output logic        core_rst_n
);

    localparam logic       BootRunBit = (BOOT_RUN != 0);
    localparam logic [7:0] RdLat      = 8'(RD_LATENCY);

    localparam logic [7:0] CmdWrImem = 8'h01;
    localparam logic [7:0] CmdRdDmem = 8'h02;
    localparam logic [7:0] CmdRdPc   = 8'h03;
    localparam logic [7:0] CmdCtrl   = 8'h10;

    typedef enum logic [3:0] {
        StIdle, StCmd, StAddr, StWrData, StCommit, StTurn, StRdData, StDone, StIgnore
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, cs_n_s, mosi_s, sclk_rise, sclk_fall;

    logic [6:0]  bit_cnt_q;
    logic [30:0] shift_in_q;
    logic [31:0] shift_in_d;
    logic [7:0]  cmd_q;
    logic [31:0] addr_q;
    logic [31:0] dmem_addr_q;
    logic [31:0] imem_addr_q, imem_data_q;
    logic        imem_we_q;
    logic        core_rst_q;
    logic [7:0]  turn_clk_q;
    logic [31:0] rd_word_q;
    logic        miso_q;

    logic shift_en, cmd_load, addr_load, commit_go;

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_s & sclk_prev_q;
    assign shift_in_d = {shift_in_q, mosi_s};

    // Synchronise the SPI pins and keep the previous sclk for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: cs_n high aborts every state before COMMIT; COMMIT always finishes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!cs_n_s) state_d = StCmd;
            StCmd: begin
                if (cs_n_s) state_d = StIdle;
                else if (sclk_rise && bit_cnt_q == 7'd7) state_d = StAddr;
            end
            StAddr: begin
                if (cs_n_s) begin
                    state_d = StIdle;
                end else if (sclk_rise && bit_cnt_q == 7'd31) begin
                    case (cmd_q)
                        CmdWrImem, CmdCtrl: state_d = StWrData;
                        CmdRdDmem, CmdRdPc: state_d = StTurn;
                        default:            state_d = StIgnore;
                    endcase
                end
            end
            StWrData: begin
                if (cs_n_s) state_d = StIdle;
                else if (sclk_rise && bit_cnt_q == 7'd31) state_d = StCommit;
            end
            StCommit: state_d = StDone;
            StTurn: begin
                if (cs_n_s) state_d = StIdle;
                else if (sclk_rise && bit_cnt_q == 7'd7) state_d = StRdData;
            end
            StRdData: begin
                if (cs_n_s) state_d = StIdle;
                else if (sclk_rise && bit_cnt_q == 7'd31) state_d = StDone;
            end
            StDone:   if (cs_n_s) state_d = StIdle;
            StIgnore: if (cs_n_s) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode: datapath enables and the gated MISO pin.
    always_comb begin
        shift_en  = sclk_rise &&
                    (state_q == StCmd || state_q == StAddr || state_q == StWrData);
        cmd_load  = (state_q == StCmd) && (state_d == StAddr);
        addr_load = (state_q == StAddr) && (state_d != StAddr) && (state_d != StIdle);
        commit_go = (state_q == StWrData) && (state_d == StCommit);
        spi_miso  = (state_q == StRdData) && miso_q;
    end

    // Bit counter clears on every state change; MOSI shifter and header capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            dmem_addr_q <= '0;
        end else begin
            if (state_d != state_q) bit_cnt_q <= '0;
            else if (sclk_rise)     bit_cnt_q <= bit_cnt_q + 7'd1;
            if (shift_en) shift_in_q <= shift_in_d[30:0];
            if (cmd_load) cmd_q <= shift_in_d[7:0];
            if (addr_load) begin
                addr_q <= shift_in_d;
                if (cmd_q == CmdRdDmem) dmem_addr_q <= shift_in_d;
            end
        end
    end

    // Commit side effects land together on the edge entering COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            core_rst_q  <= BootRunBit;
        end else begin
            imem_we_q <= commit_go && (cmd_q == CmdWrImem);
            if (commit_go && cmd_q == CmdWrImem) begin
                imem_addr_q <= addr_q;
                imem_data_q <= shift_in_d;
            end
            if (commit_go && cmd_q == CmdCtrl) core_rst_q <= shift_in_d[0];
        end
    end

    // Read path: capture the word during TURN, then shift it out on sclk falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_clk_q <= '0;
            rd_word_q  <= '0;
            miso_q     <= 1'b0;
        end else begin
            if (state_q != StTurn)    turn_clk_q <= '0;
            else if (turn_clk_q != '1) turn_clk_q <= turn_clk_q + 8'd1;

            if (state_q == StTurn) begin
                if (cmd_q == CmdRdDmem && turn_clk_q == RdLat) rd_word_q <= spi_dmem_data;
                if (cmd_q == CmdRdPc && turn_clk_q == 8'd0)    rd_word_q <= debug_pc;
            end else if (state_q == StRdData && sclk_fall) begin
                rd_word_q <= {rd_word_q[30:0], 1'b0};
            end

            if (state_q != StRdData)  miso_q <= 1'b0;
            else if (sclk_fall)       miso_q <= rd_word_q[31];
        end
    end

    assign spi_imem_we   = imem_we_q;
    assign spi_imem_addr = imem_addr_q;
    assign spi_imem_data = imem_data_q;
    assign spi_dmem_addr = dmem_addr_q;
    assign core_rst_n    = core_rst_q;

endmodule

// File: tb/tb_spi_sideload_bridge.sv
// Directed bench for spi_sideload_bridge: host-side SPI frames with a small DMEM model.
module tb_spi_sideload_bridge;

    localparam int Half = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso, spi_imem_we, core_rst_n;
    logic [31:0] spi_imem_addr, spi_imem_data, spi_dmem_addr, spi_dmem_data, debug_pc;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    logic [79:0] rx;

    always #5 clk = ~clk;

    spi_sideload_bridge #(
        .SYNC_STAGES(2),
        .RD_LATENCY (1),
        .BOOT_RUN   (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_imem_we  (spi_imem_we),
        .spi_imem_addr(spi_imem_addr),
        .spi_imem_data(spi_imem_data),
        .spi_dmem_addr(spi_dmem_addr),
        .spi_dmem_data(spi_dmem_data),
        .debug_pc     (debug_pc),
        .core_rst_n   (core_rst_n)
    );

    // One-cycle-latency DMEM holding a single known word.
    always @(posedge clk) begin
        spi_dmem_data <= (spi_dmem_addr == 32'h20) ? 32'hDEADBEEF : 32'h0;
    end

    // Count clk cycles with the write strobe high.
    always @(posedge clk) begin
        if (spi_imem_we === 1'b1) we_count <= we_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Send the first nsend bits of an nbits frame, MSB first; collect MISO at each rise.
    task automatic spi_frame(input logic [79:0] bits, input int nbits, input int nsend,
                             input bit raise_cs, output logic [79:0] miso_bits);
        miso_bits = '0;
        spi_cs_n = 1'b0;
        repeat (Half) @(negedge clk);
        for (int i = 0; i < nsend; i++) begin
            spi_mosi = bits[nbits-1-i];
            repeat (Half) @(negedge clk);
            miso_bits = {miso_bits[78:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (Half) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (Half) @(negedge clk);
        if (raise_cs) begin
            spi_cs_n = 1'b1;
            spi_mosi = 1'b0;
            repeat (2 * Half) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        debug_pc = 32'h0;
        repeat (4) @(negedge clk);

        // Reset values
        check("rst_core_rst_n", {31'b0, core_rst_n}, 32'h0);
        check("rst_miso", {31'b0, spi_miso}, 32'h0);
        check("rst_imem_we", {31'b0, spi_imem_we}, 32'h0);
        check("rst_imem_addr", spi_imem_addr, 32'h0);
        check("rst_imem_data", spi_imem_data, 32'h0);
        check("rst_dmem_addr", spi_dmem_addr, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // WR_IMEM
        spi_frame({8'h0, 8'h01, 32'h00000010, 32'h00500093}, 72, 72, 1'b1, rx);
        check("wr_we_cycles", 32'(we_count), 32'd1);
        check("wr_imem_addr", spi_imem_addr, 32'h00000010);
        check("wr_imem_data", spi_imem_data, 32'h00500093);
        check("wr_miso_zero", {31'b0, |rx[71:0]}, 32'h0);
        check("wr_core_rst_n", {31'b0, core_rst_n}, 32'h0);

        // RD_DMEM
        spi_frame({8'h02, 32'h00000020, 8'h00, 32'h0}, 80, 80, 1'b1, rx);
        check("rd_dmem_word", rx[31:0], 32'hDEADBEEF);
        check("rd_dmem_hdr_zero", {31'b0, |rx[79:32]}, 32'h0);
        check("rd_dmem_no_we", 32'(we_count), 32'd1);
        check("rd_dmem_addr", spi_dmem_addr, 32'h00000020);

        // CTRL releases the core
        spi_frame({8'h0, 8'h10, 32'h0, 32'h00000001}, 72, 72, 1'b1, rx);
        check("ctrl_core_rst_n", {31'b0, core_rst_n}, 32'h1);

        // RD_PC
        debug_pc = 32'h0000000C;
        spi_frame({8'h03, 32'hFFFFFFFF, 8'h00, 32'h0}, 80, 80, 1'b1, rx);
        check("rd_pc_word", rx[31:0], 32'h0000000C);
        check("rd_pc_dmem_addr_hold", spi_dmem_addr, 32'h00000020);

        // Abort after 50 bits, then a full write
        spi_frame({8'h0, 8'h01, 32'h00000044, 32'hCAFEF00D}, 72, 50, 1'b1, rx);
        check("abort_no_we", 32'(we_count), 32'd1);
        check("abort_imem_addr", spi_imem_addr, 32'h00000010);
        spi_frame({8'h0, 8'h01, 32'h00000044, 32'h12345678}, 72, 72, 1'b1, rx);
        check("wr2_we_cycles", 32'(we_count), 32'd2);
        check("wr2_imem_addr", spi_imem_addr, 32'h00000044);
        check("wr2_imem_data", spi_imem_data, 32'h12345678);

        // Unknown command
        spi_frame({8'h0, 8'h7F, 32'h00000020, 32'hFFFFFFFF}, 72, 72, 1'b1, rx);
        check("unk_miso_zero", {31'b0, |rx[71:0]}, 32'h0);
        check("unk_no_we", 32'(we_count), 32'd2);
        check("unk_core_rst_n", {31'b0, core_rst_n}, 32'h1);

        // rst_n pulse in the middle of a read (inside TURN)
        spi_frame({8'h02, 32'h00000020, 8'h00, 32'h0}, 80, 45, 1'b0, rx);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_core_rst_n", {31'b0, core_rst_n}, 32'h0);
        check("midrst_dmem_addr", spi_dmem_addr, 32'h0);
        check("midrst_miso", {31'b0, spi_miso}, 32'h0);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * Half) @(negedge clk);
        spi_frame({8'h02, 32'h00000020, 8'h00, 32'h0}, 80, 80, 1'b1, rx);
        check("post_rst_rd_word", rx[31:0], 32'hDEADBEEF);
        check("post_rst_no_we", 32'(we_count), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
